channel_acq_responder: RTL and testbench
========================================

# channel_acq_responder

Channel-side responder for the per-channel go/done level handshake issued by the fill trigger manager. One instance per channel (five per board). On go, it captures a programmed burst of ADC samples into the channel buffer and raises done. It holds done until the manager drops go, so the manager's "all five done" condition is stable. It also guarantees termination on disabled channels, zero-length bursts and a stalled ADC, so the manager can never hang in its fill state.

## Interface
- ADC_WIDTH, 12, ADC sample width
- ADDR_WIDTH, 10, buffer address width; buffer depth 2^ADDR_WIDTH
- TIMEOUT, 4096, maximum cycles allowed between accepted samples during acquisition (≥2, fits 16 bits)

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  level request from the trigger manager; one bit of its go bus
- done  out  1  level completion to the trigger manager
- enable  in  1  channel enable; sampled at go acceptance
- burst_len  in  ADDR_WIDTH+1  samples to capture; sampled at go acceptance
- adc_data  in  ADC_WIDTH  sample word
- adc_valid  in  1  sample strobe
- buf_we  out  1  buffer write enable
- buf_addr  out  ADDR_WIDTH  buffer write address
- buf_data  out  ADC_WIDTH  buffer write data
- samples_written  out  ADDR_WIDTH+1  samples captured in the current or last fill
- busy  out  1  high in ACQ
- timeout_err  out  1  sticky; last fill ended by timeout
- abort_err  out  1  sticky; last fill aborted by go falling in ACQ

## Operation
- States:
  - IDLE: done=0, busy=0
  - ACQ: done=0, busy=1
  - DONE: done=1, busy=0
- IDLE, go=1:
  - Latch len = min(burst_len, 2^ADDR_WIDTH).
  - Clear samples_written, timeout_err, abort_err and the idle counter.
  - If enable=0 or len=0, go to DONE; otherwise go to ACQ.
- ACQ, each cycle with adc_valid=1:
  - Write adc_data at address samples_written[ADDR_WIDTH-1:0].
  - Increment samples_written and clear the idle counter.
  - When the sample written is the len-th, go to DONE.
- ACQ, each cycle with adc_valid=0:
  - Increment the idle counter.
  - When it reaches TIMEOUT-1, set timeout_err and go to DONE.
- ACQ, go=0 has priority over sample and timeout:
  - Set abort_err and go to IDLE.
  - A sample arriving in that same cycle is not written.
- DONE:
  - Hold done=1 while go=1.
  - On go=0, go to IDLE.
  - adc_valid is ignored.
- Addresses start at 0 every fill and never wrap. len is at most 2^ADDR_WIDTH, so the last address is len-1.
- samples_written holds its value through DONE and IDLE until the next acceptance.
- buf_we is only ever high for writes of the current fill.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE; done, busy, buf_we, timeout_err, abort_err all 0; buf_addr, buf_data, samples_written all 0.
- All outputs are registered.
- Acceptance latency: go=1 sampled at edge N makes busy=1 at N+1 (ACQ), or done=1 at N+1 (disabled or zero length).
- Write latency: adc_valid at edge M makes buf_we=1 at M+1, with buf_addr and buf_data registered alongside.
- Last sample: adc_valid for the len-th sample at edge M gives buf_we=1 and done=1 together at M+1.
- Release: go=0 sampled in DONE at edge R makes done=0 at R+1.
- A new go is accepted at the earliest at R+1 (IDLE sampling go=1 at R+1 gives ACQ at R+2).
- Timeout: TIMEOUT consecutive cycles with no adc_valid in ACQ make done=1 on the next edge.
- Back-to-back samples (adc_valid high every cycle) are captured with no bubbles.
- busy and done are never high together.

## Test plan
- Normal fill:
  - Stimulus: enable=1, burst_len=8, go high, adc_valid continuous with data 0x100..0x107.
  - Required: eight writes to addresses 0..7 with matching data; done=1 in the same cycle as the write to address 7; samples_written=8.
  - Then drop go: done=0 next cycle.
- Disabled channel and zero length:
  - Stimulus: enable=0, burst_len=8, go high, then go low; repeat with enable=1, burst_len=0.
  - Required: done=1 one cycle after go in both cases, no buf_we, samples_written=0.
- Stalled ADC:
  - Stimulus: TIMEOUT=16, burst_len=8, three samples, then adc_valid held low.
  - Required: done=1 16 cycles after the last sample; timeout_err=1; samples_written=3.
  - Then drop go and issue a fresh go: timeout_err clears.
- Abort:
  - Stimulus: go dropped after four of eight samples, with adc_valid high in the drop cycle.
  - Required: state IDLE, done never set, abort_err=1, samples_written=4, no fifth write.
- Full depth and clamp:
  - Stimulus: ADDR_WIDTH=4, burst_len=31.
  - Required: 16 writes to addresses 0..15, no wrap, done after address 15, samples_written=16.
- Reset mid-acquisition:
  - Stimulus: reset_n pulsed low in ACQ and in DONE.
  - Required: all outputs take their reset values immediately.
  - After reset_n returns high with go still high: fill restarts at address 0.

Source files
------------

// File: rtl/channel_acq_responder.sv
// rtl/channel_acq_responder.sv - per-channel go/done responder that captures an ADC burst into the channel buffer
// Always terminates a fill: disabled, zero-length, stalled ADC and early go release all reach DONE or IDLE.
module channel_acq_responder #(
   parameter int ADC_WIDTH  = 12,
   parameter int ADDR_WIDTH = 10,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  go,
   output logic                  done,
   input  logic                  enable,
   input  logic [ADDR_WIDTH:0]   burst_len,
   input  logic [ADC_WIDTH-1:0]  adc_data,
   input  logic                  adc_valid,
   output logic                  buf_we,
   output logic [ADDR_WIDTH-1:0] buf_addr,
   output logic [ADC_WIDTH-1:0]  buf_data,
   output logic [ADDR_WIDTH:0]   samples_written,
   output logic                  busy,
   output logic                  timeout_err,
   output logic                  abort_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [15:0]         IDLE_LIMIT = 16'(TIMEOUT - 1);

   state_t              state, state_nx;
   logic [ADDR_WIDTH:0] len;
   logic [ADDR_WIDTH:0] clamped_len;
   logic [15:0]         idle_cnt;
   logic                accept, write, stall, tmo, abort;

   assign clamped_len = (burst_len > DEPTH) ? DEPTH : burst_len;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      write    = 1'b0;
      stall    = 1'b0;
      tmo      = 1'b0;
      abort    = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               accept   = 1'b1;
               state_nx = (!enable || clamped_len == '0) ? S_DONE : S_ACQ;
            end
         end
         S_ACQ: begin
            // Releasing go wins over a same-cycle sample or timeout.
            if (!go) begin
               abort    = 1'b1;
               state_nx = S_IDLE;
            end else if (adc_valid) begin
               write = 1'b1;
               if (samples_written + ONE == len)
                  state_nx = S_DONE;
            end else if (idle_cnt == IDLE_LIMIT) begin
               tmo      = 1'b1;
               state_nx = S_DONE;
            end else begin
               stall = 1'b1;
            end
         end
         S_DONE: begin
            if (!go)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         done            <= 1'b0;
         busy            <= 1'b0;
         buf_we          <= 1'b0;
         buf_addr        <= '0;
         buf_data        <= '0;
         samples_written <= '0;
         timeout_err     <= 1'b0;
         abort_err       <= 1'b0;
         len             <= '0;
         idle_cnt        <= '0;
      end else begin
         state  <= state_nx;
         done   <= (state_nx == S_DONE);
         busy   <= (state_nx == S_ACQ);
         buf_we <= write;
         if (accept) begin
            len             <= clamped_len;
            samples_written <= '0;
            timeout_err     <= 1'b0;
            abort_err       <= 1'b0;
            idle_cnt        <= '0;
         end
         if (write) begin
            buf_addr        <= samples_written[ADDR_WIDTH-1:0];
            buf_data        <= adc_data;
            samples_written <= samples_written + ONE;
            idle_cnt        <= '0;
         end
         if (stall)
            idle_cnt <= idle_cnt + 16'd1;
         if (tmo)
            timeout_err <= 1'b1;
         if (abort)
            abort_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_channel_acq_responder.sv
// tb/tb_channel_acq_responder.sv - directed and randomized fills checked against an arithmetic fill model
module tb_channel_acq_responder;

   localparam int ADC_WIDTH  = 12;
   localparam int ADDR_WIDTH = 4;
   localparam int TIMEOUT    = 16;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   logic                  clk;
   logic                  reset_n;
   logic                  go;
   logic                  done;
   logic                  enable;
   logic [ADDR_WIDTH:0]   burst_len;
   logic [ADC_WIDTH-1:0]  adc_data;
   logic                  adc_valid;
   logic                  buf_we;
   logic [ADDR_WIDTH-1:0] buf_addr;
   logic [ADC_WIDTH-1:0]  buf_data;
   logic [ADDR_WIDTH:0]   samples_written;
   logic                  busy;
   logic                  timeout_err;
   logic                  abort_err;

   int checks = 0;
   int errors = 0;

   channel_acq_responder #(
      .ADC_WIDTH (ADC_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .go             (go),
      .done           (done),
      .enable         (enable),
      .burst_len      (burst_len),
      .adc_data       (adc_data),
      .adc_valid      (adc_valid),
      .buf_we         (buf_we),
      .buf_addr       (buf_addr),
      .buf_data       (buf_data),
      .samples_written(samples_written),
      .busy           (busy),
      .timeout_err    (timeout_err),
      .abort_err      (abort_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk(tag, {done, busy, buf_we, timeout_err, abort_err, buf_addr, buf_data, samples_written}, 32'd0);
   endtask

   // Model: a fill ends after len samples, after TIMEOUT consecutive idle cycles, or when go drops.
   task automatic acq_fill(input logic en, input logic [ADDR_WIDTH:0] blen, input int stall_pct,
                           input int abort_at, input int stall_after, input bit ramp);
      int len, cnt, gap;
      bit fin, tmo, v;
      logic [ADC_WIDTH-1:0] d;
      len = (int'(blen) > DEPTH) ? DEPTH : int'(blen);
      enable = en; burst_len = blen; go = 1'b1; adc_valid = 1'b0;
      cyc();
      chk("acc_tmo_clr", timeout_err, 1'b0);
      chk("acc_abort_clr", abort_err, 1'b0);
      chk("acc_sw", samples_written, 32'd0);
      chk("acc_we", buf_we, 1'b0);
      if (!en || len == 0) begin
         chk("acc_done_empty", done, 1'b1);
         chk("acc_busy_empty", busy, 1'b0);
         go = 1'b0;
         cyc();
         chk("rel_done_empty", done, 1'b0);
         chk("rel_we_empty", buf_we, 1'b0);
         return;
      end
      chk("acc_busy", busy, 1'b1);
      chk("acc_done", done, 1'b0);
      cnt = 0; gap = 0; fin = 0; tmo = 0;
      for (int c = 0; c < 600 && !fin; c++) begin
         if (abort_at == cnt) begin
            adc_valid = 1'b1; adc_data = ADC_WIDTH'($urandom); go = 1'b0;
            cyc();
            chk("abort_busy", busy, 1'b0);
            chk("abort_done", done, 1'b0);
            chk("abort_we", buf_we, 1'b0);
            chk("abort_err", abort_err, 1'b1);
            chk("abort_sw", samples_written, 32'(cnt));
            adc_valid = 1'b0;
            cyc();
            chk("abort_idle", {busy, done, buf_we}, 32'd0);
            return;
         end
         if (stall_after >= 0 && cnt >= stall_after) v = 1'b0;
         else v = (int'($urandom_range(99)) >= stall_pct);
         d = ramp ? ADC_WIDTH'(12'h100 + cnt) : ADC_WIDTH'($urandom);
         adc_valid = v; adc_data = d;
         cyc();
         if (v) begin
            cnt++; gap = 0;
            chk("wr_we", buf_we, 1'b1);
            chk("wr_addr", buf_addr, 32'(cnt - 1));
            chk("wr_data", buf_data, d);
         end else begin
            gap++;
            chk("idle_we", buf_we, 1'b0);
         end
         chk("acq_sw", samples_written, 32'(cnt));
         tmo = (gap == TIMEOUT);
         fin = (cnt == len) || tmo;
         chk("acq_done", done, fin);
         chk("acq_busy", busy, !fin);
      end
      chk("fill_bound", fin, 1'b1);
      chk("end_tmo", timeout_err, tmo);
      chk("end_abort", abort_err, 1'b0);
      repeat (3) begin
         adc_valid = $urandom_range(1); adc_data = ADC_WIDTH'($urandom);
         cyc();
         chk("hold_done", done, 1'b1);
         chk("hold_we", buf_we, 1'b0);
         chk("hold_sw", samples_written, 32'(cnt));
      end
      go = 1'b0; adc_valid = 1'b0;
      cyc();
      chk("rel_done", done, 1'b0);
      chk("rel_busy", busy, 1'b0);
      chk("rel_sw", samples_written, 32'(cnt));
      chk("rel_tmo_sticky", timeout_err, tmo);
   endtask

   initial begin
      reset_n = 1'b0; go = 1'b0; enable = 1'b0; burst_len = '0;
      adc_data = '0; adc_valid = 1'b0;
      repeat (2) cyc();
      chk_reset_outs("reset_init");
      reset_n = 1'b1;
      cyc();
      chk("idle_after_reset", {busy, done}, 32'd0);

      acq_fill(1'b1, 5'd8, 0, -1, -1, 1'b1);
      acq_fill(1'b0, 5'd8, 0, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd0, 0, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd8, 0, -1, 3, 1'b0);
      acq_fill(1'b1, 5'd5, 30, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd8, 0, 4, -1, 1'b0);
      acq_fill(1'b1, 5'd31, 0, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd16, 20, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd17, 0, -1, -1, 1'b0);
      acq_fill(1'b1, 5'd4, 0, -1, 0, 1'b0);
      acq_fill(1'b1, 5'd6, 0, 0, -1, 1'b0);

      for (int i = 0; i < 25; i++) begin
         logic en;
         logic [ADDR_WIDTH:0] bl;
         int ab, lim;
         en = ($urandom_range(7) != 0);
         bl = (ADDR_WIDTH + 1)'($urandom);
         lim = (int'(bl) > DEPTH) ? DEPTH : int'(bl);
         ab = ($urandom_range(3) == 0 && lim > 0) ? int'($urandom_range(lim - 1)) : -1;
         acq_fill(en, bl, int'($urandom_range(70)), ab, -1, 1'b0);
      end

      // asynchronous reset while acquiring, go held high across it
      enable = 1'b1; burst_len = 5'd8; go = 1'b1; adc_valid = 1'b0;
      cyc();
      chk("rst_acq_busy", busy, 1'b1);
      adc_valid = 1'b1; adc_data = 12'hABC;
      repeat (2) cyc();
      #1 reset_n = 1'b0;
      #1 chk_reset_outs("reset_in_acq");
      #1 reset_n = 1'b1;
      adc_valid = 1'b0;
      cyc();
      chk("restart_busy", busy, 1'b1);
      chk("restart_sw", samples_written, 32'd0);
      adc_valid = 1'b1; adc_data = 12'h5A5;
      cyc();
      chk("restart_addr", {buf_we, 28'(buf_addr)}, {1'b1, 28'd0});
      chk("restart_data", buf_data, 12'h5A5);

      // asynchronous reset in DONE
      burst_len = 5'd2;
      go = 1'b0; adc_valid = 1'b0;
      cyc();
      acq_fill(1'b1, 5'd2, 0, -1, -1, 1'b0);
      go = 1'b1; burst_len = 5'd0;
      cyc();
      chk("rst_done_pre", done, 1'b1);
      #1 reset_n = 1'b0;
      #1 chk_reset_outs("reset_in_done");
      #1 reset_n = 1'b1;
      burst_len = 5'd3;
      cyc();
      chk("restart2_busy", busy, 1'b1);
      chk("restart2_done", done, 1'b0);
      go = 1'b0;
      cyc();
      chk("restart2_abort", abort_err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
